pid_controller: RTL

Closed-loop motor controller that consumes the gain, limit, setpoint and mode registers written by the UART command block. It produces the signed 24-bit PWM duty that drives the motor bridge and is reported back in the status frame. The loop runs one update every UPDATE_PERIOD clocks. Each update is computed by a sequential datapath with a single shared multiplier.

---
 rtl/pid_controller.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pid_controller.sv
// Closed-loop PID motor controller: one update per UPDATE_PERIOD clocks,
// computed by a sequential datapath around a single shared 24x24 multiplier.
module pid_controller #(
    parameter int unsigned UPDATE_PERIOD = 16000
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [7:0]         control_mode,
    input  logic signed [23:0] setpoint,
    input  logic signed [23:0] encoder0_position,
    input  logic signed [23:0] displacement,
    input  logic signed [23:0] Kp,
    input  logic signed [23:0] Ki,
    input  logic signed [23:0] Kd,
    input  logic [23:0]        PWMLimit,
    input  logic [23:0]        IntegralLimit,
    input  logic [23:0]        deadband,
    output logic signed [23:0] duty,
    output logic               update_done
);

    localparam int unsigned CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [22:0] LIM_MAX = 23'h7FFFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_INTEG, S_MUL_P, S_MUL_I, S_MUL_D, S_SUM, S_OUT
    } state_t;

    // Saturate a wide signed value to the 24-bit signed range.
    function automatic logic signed [23:0] sat24(input logic signed [49:0] v);
        if (v > 50'sd8388607)       return 24'sh7FFFFF;
        else if (v < -50'sd8388608) return 24'sh800000;
        else                        return 24'(v);
    endfunction

    // Symmetric clamp to +/-lim (lim is already limited to 2^23-1).
    function automatic logic signed [23:0] clamp_lim(input logic signed [49:0] v,
                                                     input logic [22:0] lim);
        logic signed [49:0] l;
        l = $signed({27'd0, lim});
        if (v > l)       return 24'(l);
        else if (v < -l) return 24'(-l);
        else             return 24'(v);
    endfunction

    state_t state, next_state;

    logic [CNT_W-1:0]   cnt;
    logic               tick;

    logic [7:0]         mode_s;
    logic signed [23:0] sp_s, meas_s, kp_s, ki_s, kd_s;
    logic [22:0]        pwm_lim_s, int_lim_s;
    logic [23:0]        db_s;

    logic signed [23:0] prev_pos;
    logic [7:0]         last_mode;
    logic signed [23:0] err, prev_err;
    logic signed [25:0] integral;
    logic signed [47:0] p_r, i_r, d_r;
    logic signed [23:0] sum_r;

    logic signed [23:0] meas_c;
    logic [22:0]        pwm_lim_c, int_lim_c;
    logic signed [24:0] err_diff, err_mag, d_diff;
    logic signed [23:0] err_sat, err_c;
    logic signed [25:0] integ_sum, integ_lim, integ_next;
    logic signed [23:0] mul_a, mul_b;
    logic signed [47:0] prod;
    logic signed [49:0] sum50;
    logic signed [23:0] sum_c;

    assign tick = (cnt == CNT_LAST);

    // Free-running update tick counter.
    always_ff @(posedge CLK) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CNT_W'(1);
    end

    // Measurement select and limit pre-clamping at snapshot time.
    always_comb begin
        meas_c = encoder0_position;
        case (control_mode)
            8'd1:    meas_c = encoder0_position - prev_pos;
            8'd2:    meas_c = displacement;
            default: ;
        endcase
        pwm_lim_c = (PWMLimit > 24'h7FFFFF) ? LIM_MAX : PWMLimit[22:0];
        int_lim_c = (IntegralLimit > 24'h7FFFFF) ? LIM_MAX : IntegralLimit[22:0];
    end

    // Datapath arithmetic: error, integrator, shared multiplier, sum.
    always_comb begin
        err_diff = 25'(sp_s) - 25'(meas_s);
        err_sat  = sat24(50'(err_diff));
        err_mag  = err_sat[23] ? -25'(err_sat) : 25'(err_sat);
        err_c    = (err_mag <= $signed({1'b0, db_s})) ? 24'sd0 : err_sat;

        integ_sum  = integral + 26'(err);
        integ_lim  = $signed({3'd0, int_lim_s});
        integ_next = integ_sum;
        if (integ_sum > integ_lim)       integ_next = integ_lim;
        else if (integ_sum < -integ_lim) integ_next = -integ_lim;

        d_diff = 25'(err) - 25'(prev_err);

        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MUL_P: begin mul_a = kp_s; mul_b = err;                    end
            S_MUL_I: begin mul_a = ki_s; mul_b = sat24(50'(integral));   end
            S_MUL_D: begin mul_a = kd_s; mul_b = sat24(50'(d_diff));     end
            default: ;
        endcase
        prod = 48'(mul_a) * 48'(mul_b);

        sum50 = 50'(p_r) + 50'(i_r) + 50'(d_r);
        if (mode_s < 8'd3)       sum_c = clamp_lim(sum50, pwm_lim_s);
        else if (mode_s == 8'd3) sum_c = clamp_lim(50'(sp_s), pwm_lim_s);
        else                     sum_c = '0;
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // FSM next-state: one cycle per stage.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (tick) next_state = S_ERR;
            S_ERR:   next_state = S_INTEG;
            S_INTEG: next_state = S_MUL_P;
            S_MUL_P: next_state = S_MUL_I;
            S_MUL_I: next_state = S_MUL_D;
            S_MUL_D: next_state = S_SUM;
            S_SUM:   next_state = S_OUT;
            S_OUT:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Snapshot, controller state and output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            mode_s      <= '0;
            sp_s        <= '0;
            meas_s      <= '0;
            kp_s        <= '0;
            ki_s        <= '0;
            kd_s        <= '0;
            pwm_lim_s   <= '0;
            int_lim_s   <= '0;
            db_s        <= '0;
            prev_pos    <= '0;
            last_mode   <= '0;
            err         <= '0;
            prev_err    <= '0;
            integral    <= '0;
            p_r         <= '0;
            i_r         <= '0;
            d_r         <= '0;
            sum_r       <= '0;
            duty        <= '0;
            update_done <= 1'b0;
        end else begin
            update_done <= 1'b0;
            if (tick) begin
                mode_s    <= control_mode;
                sp_s      <= setpoint;
                meas_s    <= meas_c;
                kp_s      <= Kp;
                ki_s      <= Ki;
                kd_s      <= Kd;
                pwm_lim_s <= pwm_lim_c;
                int_lim_s <= int_lim_c;
                db_s      <= deadband;
                prev_pos  <= encoder0_position;
            end
            case (state)
                S_ERR: begin
                    last_mode <= mode_s;
                    if (mode_s >= 8'd3) begin
                        err      <= '0;
                        integral <= '0;
                        prev_err <= '0;
                    end else begin
                        err <= err_c;
                        if (mode_s != last_mode) begin
                            integral <= '0;
                            prev_err <= '0;
                        end
                    end
                end
                S_INTEG: begin
                    if (int_lim_s == '0)  integral <= '0;
                    else if (err != '0)   integral <= integ_next;
                end
                S_MUL_P: p_r <= prod;
                S_MUL_I: i_r <= prod;
                S_MUL_D: d_r <= prod;
                S_SUM:   sum_r <= sum_c;
                S_OUT: begin
                    duty        <= sum_r;
                    prev_err    <= err;
                    update_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // An update must finish before the next tick arrives.
    always_ff @(posedge CLK) begin
        if (!reset && tick) assert (state == S_IDLE);
    end

endmodule
